// File: rtl/booth_mul_r4_seq.sv
// Sequential radix-4 Booth multiplier with valid/ready handshakes on both sides.
// Each operation can be signed or unsigned. Each RUN cycle retires two multiplier bits.
module booth_mul_r4_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] Prod,
    output logic               busy
);

    localparam int W2    = WIDTH + 2;
    localparam int N     = W2 / 2;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [W2-1:0]      m;       // latched, extended multiplicand
    logic [W2-1:0]      hi;      // upper half of the accumulator
    logic [W2-1:0]      lo;      // multiplier bits still to retire, then product low bits
    logic               bm1;     // b[2i-1] for the next Booth triplet
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod_r;

    logic [W2-1:0]      a_ext;
    logic [W2-1:0]      b_ext;
    logic [W2+1:0]      m_x;
    logic [W2+1:0]      hi_x;
    logic [W2+1:0]      pp;
    logic [W2+1:0]      sum;
    logic [2:0]         trip;

    // The two extra bits make unsigned operands look like positive signed values.
    assign a_ext = in_signed ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
    assign b_ext = in_signed ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};

    // Two guard bits absorb the +/-2M partial product before the shift.
    assign m_x  = {{2{m[W2-1]}}, m};
    assign hi_x = {{2{hi[W2-1]}}, hi};
    assign trip = {lo[1:0], bm1};

    // NOTE: pp gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        pp = '0;
        case (trip)
            3'b001, 3'b010: pp = m_x;
            3'b011:         pp = m_x << 1;
            3'b100:         pp = -(m_x << 1);
            3'b101, 3'b110: pp = -m_x;
            default:        pp = '0;
        endcase
    end

    assign sum = hi_x + pp;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            m      <= '0;
            hi     <= '0;
            lo     <= '0;
            bm1    <= 1'b0;
            cnt    <= '0;
            prod_r <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        m     <= a_ext;
                        lo    <= b_ext;
                        hi    <= '0;
                        bm1   <= 1'b0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // After N iterations, one more cycle copies the result into prod_r.
                    // This keeps Prod unchanged until the block enters DONE.
                    if (cnt == LAST) begin
                        prod_r <= {hi[WIDTH-3:0], lo};
                        state  <= S_DONE;
                    end else begin
                        hi  <= sum[W2+1:2];
                        lo  <= {sum[1:0], lo[W2-1:2]};
                        bm1 <= lo[1];
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state == S_RUN) || (state == S_DONE);
    assign Prod      = prod_r;

endmodule

// File: tb/tb_booth_mul_r4_seq.sv
// Scoreboard bench for booth_mul_r4_seq at WIDTH=16.
// A behavioural multiply produces each expected product when the operands are accepted.
module tb_booth_mul_r4_seq;

    localparam int W       = 16;
    localparam int LAT     = (W + 2) / 2 + 1;
    localparam int NSTREAM = 1000;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b1;
    logic           in_valid  = 1'b0;
    logic           in_signed = 1'b0;
    logic [W-1:0]   A         = '0;
    logic [W-1:0]   B         = '0;
    logic           out_ready = 1'b0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [2*W-1:0] Prod;

    logic [2*W-1:0] sb[$];
    int             n_checks = 0;
    int             n_fail   = 0;
    bit             hung     = 1'b0;

    booth_mul_r4_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Prod      (Prod),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic signed [2*W-1:0] x;
        logic signed [2*W-1:0] y;
        if (s) begin
            x = {{W{a[W-1]}}, a};
            y = {{W{b[W-1]}}, b};
            return x * y;
        end
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // Present the operands until they are accepted, then push the expected product.
    // The inputs are scrambled afterwards, so the DUT must rely on its latched copies.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        int k = 0;
        @(negedge clk);
        A = a; B = b; in_signed = s; in_valid = 1'b1;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
            hung = 1'b1;
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            A = W'($urandom); B = W'($urandom); in_signed = 1'(($urandom));
            sb.push_back(model(a, b, s));
        end
    endtask

    // Count rising edges after the accept until out_valid shows, sampling 1 ns after each edge.
    task automatic wait_out(output int cyc, output bit ok);
        cyc = 0; ok = 1'b0;
        while (!ok && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            ok = out_valid;
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #3;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++;
        if (Prod !== '0) begin n_fail++; $display("FAIL reset_prod: got %0h expected 0", Prod); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Run each listed operation one at a time, checking latency, status flags and the product.
    task automatic run_list(input string tag, input logic [W-1:0] av[4], input logic [W-1:0] bv[4],
                            input logic sv[4]);
        int       cyc;
        bit       ok;
        logic [2*W-1:0] exp;
        for (int i = 0; i < 4; i++) begin
            send(av[i], bv[i], sv[i]);
            n_checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_run_flags[%0d]: busy=%0b in_ready=%0b expected 1/0", tag, i, busy, in_ready);
            end
            wait_out(cyc, ok);
            exp = sb.pop_front();
            n_checks++;
            if (!ok || cyc != LAT) begin
                n_fail++;
                $display("FAIL %s_latency[%0d]: got %0d cycles expected %0d", tag, i, cyc, LAT);
            end
            n_checks++;
            if (Prod !== exp) begin
                n_fail++;
                $display("FAIL %s_prod[%0d]: got %0h expected %0h", tag, i, Prod, exp);
            end
            take();
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || Prod !== exp) begin
                n_fail++;
                $display("FAIL %s_after_take[%0d]: out_valid=%0b in_ready=%0b prod=%0h expected 0/1/%0h",
                         tag, i, out_valid, in_ready, Prod, exp);
            end
        end
    endtask

    task automatic test_signed();
        logic [W-1:0] av[4] = '{16'd12, -16'sd15, -16'sd9,  -16'sd10};
        logic [W-1:0] bv[4] = '{16'd5,  -16'sd10, 16'sd11,  -16'sd34};
        logic         sv[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        run_list("signed", av, bv, sv);
    endtask

    task automatic test_edges();
        logic [W-1:0] av[4] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000};
        logic [W-1:0] bv[4] = '{16'h8000, 16'h8000, 16'hFFFF, 16'hFFFF};
        logic         sv[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        run_list("edge", av, bv, sv);
    endtask

    task automatic test_backpressure();
        int       cyc;
        bit       ok;
        logic [2*W-1:0] p0;
        logic [2*W-1:0] exp;
        bit       seen;
        send(16'hFFF3, 16'h0101, 1'b1);
        wait_out(cyc, ok);
        p0 = Prod;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'(i % 2);
            A = W'($urandom); B = W'($urandom);
            @(posedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || Prod !== p0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: out_valid=%0b prod=%0h in_ready=%0b expected 1/%0h/0",
                         i, out_valid, Prod, in_ready, p0);
            end
        end
        in_valid = 1'b0;
        exp = sb.pop_front();
        n_checks++;
        if (Prod !== exp) begin n_fail++; $display("FAIL hold_prod: got %0h expected %0h", Prod, exp); end
        take();
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            seen = seen | busy | out_valid;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL ignored_pulses: busy/out_valid=%0b expected 0", seen); end
    endtask

    task automatic test_reset_abort();
        int       cyc;
        bit       ok;
        bit       seen;
        logic [2*W-1:0] exp;
        send(16'd100, 16'd200, 1'b1);
        void'(sb.pop_back());
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || Prod !== '0) begin
            n_fail++;
            $display("FAIL abort_reset: in_ready=%0b out_valid=%0b busy=%0b prod=%0h expected 1/0/0/0",
                     in_ready, out_valid, busy, Prod);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_result: out_valid=%0b expected 0", seen); end
        send(16'd7, 16'hFFFD, 1'b1);
        wait_out(cyc, ok);
        exp = sb.pop_front();
        n_checks++;
        if (!ok || Prod !== exp) begin
            n_fail++;
            $display("FAIL abort_next_op: got %0h valid=%0b expected %0h", Prod, ok, exp);
        end
        take();
    endtask

    task automatic test_stream();
        int got = 0;
        int cyc = 0;
        logic [2*W-1:0] exp;
        fork
            begin
                for (int i = 0; i < NSTREAM && !hung; i++) begin
                    send(W'($urandom), W'($urandom), 1'($urandom));
                end
            end
            begin
                while (got < NSTREAM && cyc < 40000 && !hung) begin
                    @(negedge clk);
                    out_ready = 1'($urandom_range(0, 1));
                    cyc++;
                    if (out_valid && out_ready) begin
                        n_checks++;
                        if (sb.size() == 0) begin
                            n_fail++;
                            $display("FAIL stream_extra[%0d]: got %0h with no pending operation", got, Prod);
                        end else begin
                            exp = sb.pop_front();
                            if (Prod !== exp) begin
                                n_fail++;
                                $display("FAIL stream_prod[%0d]: got %0h expected %0h", got, Prod, exp);
                            end
                        end
                        got++;
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                hung = hung || (got < NSTREAM);
            end
        join
        n_checks++;
        if (got != NSTREAM || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stream_count: got %0d results with %0d pending, expected %0d with 0 pending",
                     got, sb.size(), NSTREAM);
        end
    endtask

    initial begin
        test_reset();
        test_signed();
        test_edges();
        test_backpressure();
        test_reset_abort();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
